hwjsoc_cpu_ocimem_arbiter: RTL
==============================

// Module: hwjsoc_cpu_ocimem_arbiter
// PURPOSE
//  Sysclk-domain controller for the CPU on-chip debug memory (OCI RAM). Decodes ocimem
//  commands (jdo + take_action strobes) from the JTAG debug module and sequences
//  single-word reads/writes with an address auto-increment. Shares the single-port
//  RAM with the CPU's Avalon debug slave under round-robin arbitration, and returns
//  JTAG read data on MonDReg.
// PARAMETERS
//  ADDR_W   8    OCI RAM word-address width; RAM depth = 2**ADDR_W
//  DATA_W   32   data width; fixed at 32 (jdo[34:3] carries write data)
// PORTS
//  clk                      in   1       system clock
//  reset_n                  in   1       synchronous active-low reset
//  jdo                      in   38      JTAG command/data word, sampled on a strobe
//  take_action_ocimem_a     in   1       load jaddr = jdo[17+:ADDR_W]; if jdo[34]=1, queue read
//  take_no_action_ocimem_a  in   1       queue read at jaddr
//  take_action_ocimem_b     in   1       queue write of jdo[34:3] at jaddr
//  avs_address              in   ADDR_W  CPU word address
//  avs_read / avs_write     in   1       CPU request; held until waitrequest=0
//  avs_writedata            in   32      CPU write data
//  avs_readdata             out  32      CPU read data; valid when waitrequest=0 on a read
//  avs_waitrequest          out  1       Avalon stall
//  ram_addr                 out  ADDR_W  RAM address
//  ram_wren / ram_rden      out  1       RAM strobes; never both high
//  ram_wdata                out  32      RAM write data
//  ram_rdata                in   32      RAM read data; 1-cycle latency after ram_rden
//  MonDReg                  out  32      last JTAG read result
//  monitor_ready            out  1       JTAG op complete; level
//  jtag_overrun             out  1       sticky: a JTAG strobe arrived while jpend=1
// BEHAVIOUR
//  Reset: state=IDLE, jpend=0, jaddr=0, last_grant=CPU, MonDReg=0, monitor_ready=0,
//   jtag_overrun=0, ram_wren=ram_rden=0. avs_waitrequest = avs_read|avs_write during reset.
//  JTAG strobes are mutually exclusive. Any strobe clears monitor_ready.
//   jpend=1 when a strobe queues an op; jop/jwdata are latched.
//   A strobe while jpend=1: dropped, jtag_overrun<=1; jaddr/jop are unchanged.
//   take_action_ocimem_a with jdo[34]=0 only loads jaddr; no op is queued.
//  FSM states: IDLE, JACC, JRD, CACC, CRD.
//   IDLE: grant if any request is pending.
//    - If both jpend and a CPU request are pending, grant the side opposite last_grant.
//    - Otherwise grant the single requester.
//    - Next state is JACC or CACC; last_grant is updated.
//   JACC: ram_addr=jaddr; ram_wren (write) or ram_rden (read); jpend<=0;
//    jaddr<=jaddr+1, wrapping 2**ADDR_W-1 -> 0.
//    - Write: -> IDLE, monitor_ready<=1.
//    - Read: -> JRD.
//   JRD: MonDReg<=ram_rdata, monitor_ready<=1; -> IDLE.
//   CACC: ram_addr=avs_address; strobe per request.
//    - Write: waitrequest=0 this cycle; -> IDLE.
//    - Read: -> CRD.
//   CRD: avs_readdata=ram_rdata, waitrequest=0; -> IDLE.
//  avs_waitrequest=1 whenever avs_read|avs_write is high, except in the completing cycle.
//  Latency from IDLE grant:
//   - CPU write: 2 cycles to waitrequest low.
//   - CPU read: 3 cycles to waitrequest low.
//   - JTAG read: MonDReg valid 3 cycles after strobe.
//  A strobe arriving in the same cycle as the IDLE decision is not considered until the next IDLE.
//  avs_read and avs_write both high: treated as write.
//  Reset asserted mid-op: the op is abandoned; no RAM strobe occurs in the cycle after reset.
// TESTING
//  1 Strobe ocimem_a, jdo[17+:8]=8'h10, jdo[34]=1; RAM[0x10]=32'hDEADBEEF
//    -> ram_rden@0x10; MonDReg=DEADBEEF; monitor_ready=1; jaddr=0x11.
//  2 ocimem_b with jdo[34:3]=32'h12345678, then take_no_action_ocimem_a
//    -> RAM[0x11] written; readback at 0x12; jaddr=0x13.
//  3 CPU read and JTAG read pending in the same IDLE cycle from reset
//    -> JTAG granted first, then CPU; CPU waitrequest held until CRD.
//  4 jaddr=0xFF, write -> RAM[0xFF] written; jaddr wraps to 0x00.
//  5 Second ocimem_b while jpend=1 -> jtag_overrun=1; only the first write reaches RAM.
//  6 reset_n low during CRD -> IDLE next cycle; no strobes; all outputs at reset values.

Source files
------------

// File: rtl/hwjsoc_cpu_ocimem_arbiter.sv
// OCI debug RAM controller: JTAG ocimem command sequencer
// sharing the single-port RAM with the CPU Avalon debug slave.
module hwjsoc_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic              ram_rden,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  typedef enum logic [2:0] {
    IDLE, JACC, JRD, CACC, CRD
  } state_t;

  state_t state, state_nx;

  logic              jpend;
  logic              jop_wr;
  logic [DATA_W-1:0] jwdata;
  logic [ADDR_W-1:0] jaddr;
  logic              last_jtag;
  logic              cpu_req;
  logic              strobe;
  logic              grant_j;
  logic              cpu_done;
  logic              unused_jdo;

  assign cpu_req    = avs_read | avs_write;
  assign strobe     = take_action_ocimem_a
                    | take_no_action_ocimem_a
                    | take_action_ocimem_b;
  assign grant_j    = jpend & (~cpu_req | ~last_jtag);
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // next-state: round-robin grant from IDLE, fixed op sequences
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (grant_j)      state_nx = JACC;
        else if (cpu_req) state_nx = CACC;
      end
      JACC:    state_nx = jop_wr ? IDLE : JRD;
      JRD:     state_nx = IDLE;
      CACC:    state_nx = avs_write ? IDLE : CRD;
      CRD:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // RAM port and Avalon responses; all quiet while in reset
  always_comb begin
    ram_addr     = jaddr;
    ram_wren     = 1'b0;
    ram_rden     = 1'b0;
    ram_wdata    = jwdata;
    avs_readdata = '0;
    cpu_done     = 1'b0;
    if (reset_n) begin
      unique case (state)
        JACC: begin
          ram_wren = jop_wr;
          ram_rden = ~jop_wr;
        end
        CACC: begin
          ram_addr  = avs_address;
          ram_wdata = avs_writedata;
          ram_wren  = avs_write;
          ram_rden  = ~avs_write & avs_read;
          cpu_done  = avs_write;
        end
        CRD: begin
          avs_readdata = ram_rdata;
          cpu_done     = 1'b1;
        end
        default: ;
      endcase
    end
    avs_waitrequest = cpu_req & ~cpu_done;
  end

  // JTAG command capture, address increment and result return
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      jpend         <= 1'b0;
      jop_wr        <= 1'b0;
      jwdata        <= '0;
      jaddr         <= '0;
      last_jtag     <= 1'b0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      jtag_overrun  <= 1'b0;
    end else begin
      if (state == IDLE && state_nx != IDLE)
        last_jtag <= (state_nx == JACC);
      if (state == JACC) begin
        jpend <= 1'b0;
        jaddr <= jaddr + ADDR_W'(1);
        if (jop_wr) monitor_ready <= 1'b1;
      end
      if (state == JRD) begin
        MonDReg       <= ram_rdata;
        monitor_ready <= 1'b1;
      end
      // a fresh command supersedes any completion flag
      if (strobe) begin
        monitor_ready <= 1'b0;
        if (jpend) begin
          jtag_overrun <= 1'b1;
        end else if (take_action_ocimem_a) begin
          jaddr <= jdo[17+:ADDR_W];
          if (jdo[34]) begin
            jpend  <= 1'b1;
            jop_wr <= 1'b0;
          end
        end else if (take_no_action_ocimem_a) begin
          jpend  <= 1'b1;
          jop_wr <= 1'b0;
        end else begin
          jpend  <= 1'b1;
          jop_wr <= 1'b1;
          jwdata <= jdo[3+:DATA_W];
        end
      end
    end
  end

endmodule
